// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a byte FIFO, sharing the core's data-memory port.
// Optional macro MMIO_UART_TX_PARITY_EN inserts an even-parity bit (8E1); the default build sends 8N1.
module mmio_uart_tx #(
   parameter logic [31:0] ADDR_BASE    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWriteEnable,
   input  logic        MemReadEnable,
   input  logic [3:0]  MemByteEnable,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        TxD,
   output logic        TxBusy
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } txState_e;

   logic inWindow, isStatus, pushReq, clearOvf, pushAccept;
   logic unusedBits;

   assign inWindow   = (Address[31:3] == ADDR_BASE[31:3]);
   assign Hit        = inWindow && (MemReadEnable || MemWriteEnable);
   assign isStatus   = Address[2];
   assign pushReq    = Hit && MemWriteEnable && !isStatus && MemByteEnable[0];
   assign clearOvf   = Hit && MemWriteEnable && isStatus;
   assign unusedBits = ^{Address[1:0], WriteData[31:8], MemByteEnable[3:1]};

   logic [7:0]       fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [CNT_W-1:0] count;
   logic             full, empty, pop, overflow;
   logic [7:0]       headByte;

   assign full       = (count == CNT_FULL);
   assign empty      = (count == '0);
   assign headByte   = fifoMem[rdPtr];
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign pushAccept = pushReq && (!full || pop);

   // NOTE: the storage array has no reset; count and pointers alone decide which entries are valid.
   always_ff @(posedge CLK) begin
      if (pushAccept) fifoMem[wrPtr] <= WriteData[7:0];
   end

   // NOTE: clocked state is written with non-blocking assignments only; combinational blocks use blocking.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pushAccept) wrPtr <= wrPtr + 1'b1;
         if (pop)        rdPtr <= rdPtr + 1'b1;
         case ({pushAccept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (clearOvf)                    overflow <= 1'b0;
         else if (pushReq && full && !pop) overflow <= 1'b1;
      end
   end

   txState_e          state, stateNext;
   logic [BAUD_W-1:0] baudCnt, baudNext;
   logic [2:0]        bitCnt, bitNext;
   logic [7:0]        shiftReg, shiftNext;
   logic              baudDone, txdNext;
`ifdef MMIO_UART_TX_PARITY_EN
   logic              parityReg, parityNext;
`endif

   assign baudDone = (baudCnt == BAUD_LAST);
   assign TxBusy   = (state != IDLE);

   // NOTE: every signal of this block gets a default first, so no path can infer a latch.
   always_comb begin
      stateNext = state;
      baudNext  = baudCnt;
      bitNext   = bitCnt;
      shiftNext = shiftReg;
      pop       = 1'b0;
      txdNext   = 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      parityNext = parityReg;
`endif
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               stateNext = START;
               baudNext  = '0;
               bitNext   = '0;
            end
         end
         START: begin
            if (baudDone) begin
               stateNext = DATA;
               baudNext  = '0;
            end else baudNext = baudCnt + 1'b1;
         end
         DATA: begin
            if (baudDone) begin
               baudNext  = '0;
               shiftNext = {1'b0, shiftReg[7:1]};
               if (bitCnt == 3'd7) begin
                  bitNext = '0;
`ifdef MMIO_UART_TX_PARITY_EN
                  stateNext = PARITY;
`else
                  stateNext = STOP;
`endif
               end else bitNext = bitCnt + 1'b1;
            end else baudNext = baudCnt + 1'b1;
         end
`ifdef MMIO_UART_TX_PARITY_EN
         PARITY: begin
            if (baudDone) begin
               stateNext = STOP;
               baudNext  = '0;
            end else baudNext = baudCnt + 1'b1;
         end
`endif
         STOP: begin
            if (baudDone) begin
               baudNext = '0;
               if (!empty) begin
                  pop       = 1'b1;
                  stateNext = START;
               end else stateNext = IDLE;
            end else baudNext = baudCnt + 1'b1;
         end
         default: stateNext = IDLE;
      endcase

      if (pop) begin
         shiftNext = headByte;
`ifdef MMIO_UART_TX_PARITY_EN
         parityNext = ^headByte;
`endif
      end

      // The line level is registered from the next state so TxD never glitches.
      case (stateNext)
         START:   txdNext = 1'b0;
         DATA:    txdNext = shiftNext[0];
`ifdef MMIO_UART_TX_PARITY_EN
         PARITY:  txdNext = parityNext;
`endif
         default: txdNext = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitCnt   <= '0;
         shiftReg <= '0;
         TxD      <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
         parityReg <= 1'b0;
`endif
      end else begin
         state    <= stateNext;
         baudCnt  <= baudNext;
         bitCnt   <= bitNext;
         shiftReg <= shiftNext;
         TxD      <= txdNext;
`ifdef MMIO_UART_TX_PARITY_EN
         parityReg <= parityNext;
`endif
      end
   end

   // The count field is log2(FIFO_DEPTH) bits wide, so it reads 0 at full; the full flag disambiguates.
   always_comb begin
      ReadData = '0;
      if (Hit && isStatus) begin
         ReadData[0]          = full;
         ReadData[1]          = empty;
         ReadData[2]          = TxBusy;
         ReadData[3]          = overflow;
         ReadData[8 +: PTR_W] = count[PTR_W-1:0];
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected bytes, busy periods and register reads;
// independent monitors decode TxD, time TxBusy and compare every load.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam int CPB = 16;
`ifdef MMIO_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] Address, WriteData, ReadData;
   logic        MemWriteEnable, MemReadEnable, Hit, TxD, TxBusy;
   logic [3:0]  MemByteEnable;

   always #5 CLK = ~CLK;

   mmio_uart_tx #(.ADDR_BASE(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .CLK(CLK), .RST(RST), .Address(Address), .WriteData(WriteData),
      .MemWriteEnable(MemWriteEnable), .MemReadEnable(MemReadEnable),
      .MemByteEnable(MemByteEnable), .ReadData(ReadData), .Hit(Hit),
      .TxD(TxD), .TxBusy(TxBusy)
   );

   int compared = 0;
   int mismatched = 0;

   logic [7:0]  byteQ[$];
   int          busyQ[$];
   logic        readHitQ[$];
   logic [31:0] readDataQ[$];
   string       readNameQ[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("FAIL %s: got 0x%h, required 0x%h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [10:0] makeFrame(input logic [7:0] b);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
`ifdef MMIO_UART_TX_PARITY_EN
      f[9]   = ^b;
`endif
      return f;
   endfunction

   // Load monitor
   logic        expHit;
   logic [31:0] expData;
   string       expName;
   always @(negedge CLK) begin
      if (MemReadEnable) begin
         if (readDataQ.size() == 0) failNow("load with no expectation queued");
         else begin
            expHit  = readHitQ.pop_front();
            expData = readDataQ.pop_front();
            expName = readNameQ.pop_front();
            check({expName, " Hit"}, 32'(Hit), 32'(expHit));
            check({expName, " ReadData"}, ReadData, expData);
         end
      end
   end

   // Serial frame monitor
   logic [10:0] frameBits;
   logic [7:0]  curByte;
   int          bitIdx, bitCyc, badCyc, gapRun, waitRun;
   bit          inFrame = 1'b0, gapArmed = 1'b0, rogue = 1'b0;
   always @(negedge CLK) begin
      if (RST) begin
         inFrame  = 1'b0;
         gapArmed = 1'b0;
         gapRun   = 0;
         waitRun  = 0;
      end else if (!inFrame) begin
         if (TxD === 1'b0) begin
            rogue = (byteQ.size() == 0);
            if (rogue) failNow("unexpected frame start on TxD");
            else begin
               if (gapArmed) check("idle cycles between frames", 32'(gapRun), 32'd0);
               curByte   = byteQ.pop_front();
               frameBits = makeFrame(curByte);
            end
            inFrame  = 1'b1;
            bitIdx   = 0;
            bitCyc   = 1;
            badCyc   = 0;
            gapArmed = 1'b0;
            waitRun  = 0;
         end else begin
            gapRun++;
            if (byteQ.size() == 0) waitRun = 0;
            else begin
               waitRun++;
               if (waitRun > 2 * FRAME_CYC) begin
                  failNow("queued byte never started a frame");
                  byteQ.delete();
                  waitRun = 0;
               end
            end
         end
      end else begin
         if (TxD !== frameBits[bitIdx]) badCyc++;
         bitCyc++;
         if (bitCyc == CPB) begin
            if (!rogue)
               check($sformatf("byte %h frame bit %0d wrong cycles", curByte, bitIdx), 32'(badCyc), 32'd0);
            bitIdx++;
            bitCyc = 0;
            badCyc = 0;
            if (bitIdx == FRAME_BITS) begin
               inFrame  = 1'b0;
               gapRun   = 0;
               gapArmed = (byteQ.size() != 0);
            end
         end
      end
   end

   // Busy-period monitor
   int busyRun;
   bit inBusy = 1'b0;
   always @(negedge CLK) begin
      if (RST) inBusy = 1'b0;
      else if (TxBusy) begin
         if (!inBusy) begin
            inBusy  = 1'b1;
            busyRun = 0;
         end
         busyRun++;
      end else if (inBusy) begin
         inBusy = 1'b0;
         if (busyQ.size() == 0) failNow("unexpected TxBusy period");
         else check("TxBusy period length", 32'(busyRun), 32'(busyQ.pop_front()));
      end
   end

   // Line state right after every reset edge
   logic rstEdge = 1'b0;
   always @(posedge CLK) rstEdge <= RST;
   always @(negedge CLK) begin
      if (rstEdge) begin
         check("TxD after reset edge", 32'(TxD), 32'd1);
         check("TxBusy after reset edge", 32'(TxBusy), 32'd0);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      Address        = addr;
      WriteData      = data;
      MemByteEnable  = be;
      MemWriteEnable = 1'b1;
      tick(1);
      MemWriteEnable = 1'b0;
      MemByteEnable  = 4'b0000;
      Address        = '0;
      WriteData      = '0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      byteQ.push_back(b);
      busWrite(BASE, {24'hDEADBE, b}, 4'b0001);
   endtask

   task automatic busRead(input string name, input logic [31:0] addr, input logic hit, input logic [31:0] data);
      readNameQ.push_back(name);
      readHitQ.push_back(hit);
      readDataQ.push_back(data);
      Address       = addr;
      MemReadEnable = 1'b1;
      tick(1);
      MemReadEnable = 1'b0;
      Address       = '0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (TxBusy && n < 30 * FRAME_CYC) begin
         tick(1);
         n++;
      end
      check("transmitter drained within budget", 32'(TxBusy), 32'd0);
      tick(4);
   endtask

   logic [7:0] burst9 [9] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h7E};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; Address = '0; WriteData = '0;
      MemWriteEnable = 1'b0; MemReadEnable = 1'b0; MemByteEnable = 4'b0000;
      tick(3);
      RST = 1'b0;
      tick(2);

      // Single byte 0x55; STATUS one cycle after the store, then once the pop has happened
      busRead("status after reset", BASE + 32'd4, 1'b1, 32'h0000_0002);
      busRead("txdata reads zero", BASE, 1'b1, 32'h0000_0000);
      busyQ.push_back(FRAME_CYC);
      sendByte(8'h55);
      busRead("status one entry queued", BASE + 32'd4, 1'b1, 32'h0000_0100);
      busRead("status while sending", BASE + 32'd4, 1'b1, 32'h0000_0006);
      waitIdle();
      busRead("status idle after frame", BASE + 32'd4, 1'b1, 32'h0000_0002);

      // Nine back-to-back bytes: FIFO reaches 8 entries (count field reads 0, full=1), no overflow
      busyQ.push_back(9 * FRAME_CYC);
      for (int i = 0; i < 9; i++) sendByte(burst9[i]);
      busRead("status full nine stores", BASE + 32'd4, 1'b1, 32'h0000_0005);
      waitIdle();
      busRead("status after nine frames", BASE + 32'd4, 1'b1, 32'h0000_0002);

      // Ten bytes: the tenth is dropped and overflow sticks until a STATUS store
      busyQ.push_back(9 * FRAME_CYC);
      for (int i = 0; i < 9; i++) sendByte(8'h10 + 8'(i));
      busWrite(BASE, 32'h0000_00EE, 4'b0001);
      busRead("status overflow while full", BASE + 32'd4, 1'b1, 32'h0000_000D);
      waitIdle();
      busRead("status overflow sticky", BASE + 32'd4, 1'b1, 32'h0000_000A);
      busWrite(BASE + 32'd4, 32'hFFFF_FFFF, 4'b1111);
      busRead("status overflow cleared", BASE + 32'd4, 1'b1, 32'h0000_0002);

      // Lane 0 disabled, out-of-window accesses, ignored low address bits
      busWrite(BASE, 32'h0000_0099, 4'b1110);
      busWrite(BASE + 32'd8, 32'h0000_0077, 4'b0001);
      busRead("status after masked store", BASE + 32'd4, 1'b1, 32'h0000_0002);
      busRead("load above window", BASE + 32'd8, 1'b0, 32'h0000_0000);
      busRead("load below window", BASE - 32'd4, 1'b0, 32'h0000_0000);
      busRead("status with low bits set", BASE + 32'd6, 1'b1, 32'h0000_0002);
      tick(40);

      // Store to a full FIFO exactly on the STOP->START pop edge
      busyQ.push_back(10 * FRAME_CYC);
      for (int i = 0; i < 9; i++) sendByte(8'h20 + 8'(i));
      tick(FRAME_CYC - 8);
      sendByte(8'hC7);
      busRead("status store on pop edge", BASE + 32'd4, 1'b1, 32'h0000_0005);
      waitIdle();
      busRead("status after pop-edge store", BASE + 32'd4, 1'b1, 32'h0000_0002);

      // Reset in the middle of the data bits of 0xA5 with three bytes queued
      sendByte(8'hA5);
      busWrite(BASE, 32'h0000_0012, 4'b0001);
      busWrite(BASE, 32'h0000_0034, 4'b0001);
      busWrite(BASE, 32'h0000_0056, 4'b0001);
      tick(40);
      RST = 1'b1;
      byteQ.delete();
      tick(2);
      RST = 1'b0;
      busRead("status after mid-frame reset", BASE + 32'd4, 1'b1, 32'h0000_0002);
      tick(3 * FRAME_CYC);

      // 0x07 has odd weight, so the even-parity bit is 1 when parity is built in
      busyQ.push_back(FRAME_CYC);
      sendByte(8'h07);
      busRead("status before 0x07 frame", BASE + 32'd4, 1'b1, 32'h0000_0100);
      waitIdle();

      tick(10);
      check("frames still expected", 32'(byteQ.size()), 32'd0);
      check("busy periods still expected", 32'(busyQ.size()), 32'd0);
      check("loads still expected", 32'(readDataQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the core's data-memory port, alongside `data_memory`. Decodes core loads/stores in a fixed 8-byte window, queues stored bytes in a FIFO, and serialises them on `TxD` as asynchronous frames. The board top routes `ReadData` from this block when `Hit` is high, otherwise from `data_memory`.

## Interface
- `ADDR_BASE`, default 32'hFFFF_0000: window base, 8-byte aligned.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, at least 2.
- `FIFO_DEPTH`, default 8: byte entries, power of two, at least 2.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Address` in 32: core data address (`ReadAddress` net).
- `WriteData` in 32: store data.
- `MemWriteEnable` in 1: store strobe.
- `MemReadEnable` in 1: load strobe.
- `MemByteEnable` in 4: byte lanes.
- `ReadData` out 32: register read data, combinational.
- `Hit` out 1: access falls in window, combinational.
- `TxD` out 1: serial output, idle high.
- `TxBusy` out 1: high whenever the FSM is not IDLE.

## Operation
- Decode:
  - `Hit` = (`Address[31:3]` == `ADDR_BASE[31:3]`) && (`MemReadEnable` || `MemWriteEnable`).
  - `Address[2]` selects the register. `Address[1:0]` is ignored.
- TXDATA, offset 0:
  - Store with `MemByteEnable[0]`=1 pushes `WriteData[7:0]`.
  - Store with `MemByteEnable[0]`=0 is ignored.
  - Reads return 0.
- STATUS, offset 4, read:
  - bit0 full; bit1 empty; bit2 busy; bit3 overflow (sticky).
  - bits[7+log2(FIFO_DEPTH):8] hold the entry count; all other bits are 0.
- Any store to STATUS clears overflow.
- When `Hit`=0, `ReadData` = 0.
- Push when full:
  - Byte is dropped and overflow is set.
  - Exception: if the FSM pops on the same edge, the push is accepted, count is unchanged and overflow is not set.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE→START when the FIFO is non-empty. The head byte is popped into the shift register on that edge.
  - START: `TxD`=0.
  - DATA: 8 bits, LSB first.
  - STOP: `TxD`=1.
  - Each state or bit lasts exactly `CLKS_PER_BIT` cycles, timed by a baud counter and a 3-bit bit counter.
  - STOP end: go to START with a pop if the FIFO is non-empty, else go to IDLE. No idle gap between back-to-back frames.
- Reset values: `TxD`=1, `TxBusy`=0, FIFO empty, overflow=0, state IDLE, counters 0. `ReadData` and `Hit` are combinational.
- Reset mid-frame: the frame is aborted, queued bytes are discarded, and `TxD`=1 from the next edge.

## Timing
- A store is captured on rising edge k. The FSM pops on edge k+1 if idle.
- `TxD` falls after edge k+1 and stays low for `CLKS_PER_BIT` cycles.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- `TxBusy` rises after edge k+1 and falls after the final STOP cycle when the FIFO is empty.
- STATUS reflects state after the last edge. A push at edge k is visible in STATUS during cycle k+1.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Full/empty are derived from the count, not from pointer equality.

## Configuration
- `MMIO_UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - `TxD` = XOR of the 8 data bits (even parity).
  - Frame is 8E1.
- Not defined:
  - PARITY state and logic are absent.
  - Frame is 8N1.

## Test plan
- Reset, then store 32'h0000_0055 with enable 4'b0001 to `ADDR_BASE`.
  - `TxD` sequence is 0,1,0,1,0,1,0,1,0,1, each held 16 cycles.
  - `TxBusy` drops after 160 cycles.
- Store 9 bytes back-to-back while the first frame is in progress.
  - Nine frames are sent with no gaps; no overflow.
  - Repeat with 10 bytes: one byte is dropped and STATUS bit3=1.
  - Then store any value to `ADDR_BASE`+4: STATUS bit3=0.
- Store to `ADDR_BASE` with enable 4'b1110: no push, STATUS reads 32'h0000_0002.
  - Load from `ADDR_BASE`+8: `Hit`=0 and `ReadData`=0.
- With FIFO full, store exactly on the STOP→START pop edge.
  - Byte is accepted, count stays 8, overflow stays 0.
- Assert `RST` mid-DATA of byte 8'hA5 with 3 bytes queued.
  - `TxD`=1 the next cycle; STATUS reads 32'h0000_0002; no further frames.
- With the macro defined, send 8'h07.
  - Frame is 11 bits; parity bit is 1.
